// File: rtl/easy_fifo_pkg.sv
// Shared sizing helpers for the easy_fifo read-side adapter.
// The output buffer holds RD_LATENCY+2 words, which lets reads keep flowing at one per cycle.
package easy_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2(depth);
  endfunction

  function automatic int occ_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/easy_fifo_rd_pipe.sv
// Tracks reads that are still in flight inside the FIFO's read pipeline.
// Each stage is a valid bit; the last stage marks the cycle in which rd_data is valid.
module easy_fifo_rd_pipe
  import easy_fifo_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = clog2(RD_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_i,
  output logic             land_o,
  output logic [CNT_W-1:0] inflight_o
);

  logic [RD_LATENCY-1:0] stage_q;
  logic [RD_LATENCY-1:0] stage_d;

  assign stage_d[0] = issue_i;

  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_shift
    assign stage_d[gi] = stage_q[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign land_o = stage_q[RD_LATENCY-1];

  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_o = inflight_o + CNT_W'(stage_q[i]);
    end
  end

endmodule

// File: rtl/easy_fifo_rd2axis.sv
// Drains a non-FWFT easy_fifo read port into an AXI4-Stream master via a credit-managed buffer.
// Define EASY_FIFO_TLAST_GEN_EN to generate TLAST every PKT_LEN beats; otherwise TLAST is held at 0.
module easy_fifo_rd2axis
  import easy_fifo_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int RD_LATENCY = 1,
  parameter int PKT_LEN    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rd_en,
  input  logic [DWIDTH-1:0] rd_data,
  input  logic              rd_empty,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int PTR_W     = ptr_width(BUF_DEPTH);
  localparam int OCC_W     = occ_width(BUF_DEPTH);
  localparam int INF_W     = clog2(RD_LATENCY + 1);
  localparam int SUM_W     = OCC_W + 1;

  logic [DWIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [INF_W-1:0]  inflight;
  logic [SUM_W-1:0]  credit_sum;
  logic              land;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  easy_fifo_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .CNT_W      (INF_W)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_i    (rd_en),
    .land_o     (land),
    .inflight_o (inflight)
  );

  // Credits count both buffered words and words still in the FIFO pipeline,
  // so tready never reaches rd_en combinationally.
  assign credit_sum    = SUM_W'(occ_q) + SUM_W'(inflight);
  assign rd_en         = !rd_empty && (credit_sum < SUM_W'(BUF_DEPTH)) && rst_n;
  assign m_axis_tvalid = (occ_q != '0);
  assign m_axis_tdata  = buf_q[rd_ptr_q];
  assign pop           = m_axis_tvalid && m_axis_tready;

  always_comb begin
    wr_ptr_d = land ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    case ({land, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // The head entry is only overwritten after it has been popped, keeping tdata stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (land) begin
      buf_q[wr_ptr_q] <= rd_data;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(land && (occ_q == OCC_W'(BUF_DEPTH))));

`ifdef EASY_FIFO_TLAST_GEN_EN
  localparam int CNT_W = clog2(PKT_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = (cnt_q == CNT_W'(PKT_LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m_axis_tlast = m_axis_tvalid && (cnt_q == CNT_W'(PKT_LEN - 1));
`else
  logic unused_pkt_len;
  assign unused_pkt_len = (PKT_LEN != 0);
  assign m_axis_tlast   = 1'b0;
`endif

endmodule

// File: doc/easy_fifo_rd2axis.md
# easy_fifo_rd2axis

Read-side adapter that drains a standard (non-FWFT) easy_fifo read port and presents the words as an AXI4-Stream master. It hides the FIFO's fixed read latency behind a small credit-managed output buffer, sustaining one beat per cycle while `m_axis_tready` is high. It sits between an `easy_fifo_sync` read port and any AXIS consumer, in the same clock domain as the FIFO's read side.

## Interface
- `DWIDTH`, 32: data width, ≥1.
- `RD_LATENCY`, 1: cycles from accepted `rd_en` to valid `rd_data`; legal values 1 to 3.
- `PKT_LEN`, 16: beats per packet for TLAST generation; ≥1. Used only with `EASY_FIFO_TLAST_GEN_EN`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `rd_en` out 1: FIFO read request.
- `rd_data` in DWIDTH: FIFO read data, valid RD_LATENCY cycles after an accepted read.
- `rd_empty` in 1: FIFO empty flag.
- `m_axis_tdata` out DWIDTH: output beat data.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tlast` out 1: end-of-packet marker.
- `m_axis_tready` in 1: consumer ready.

## Operation
- Buffer depth `BUF_DEPTH = RD_LATENCY + 2` entries. Circular write and read pointers wrap at BUF_DEPTH. Occupancy counter `occ` ranges 0..BUF_DEPTH.
- In-flight tracker: RD_LATENCY-stage valid shift register. `inflight` is its popcount.
- `rd_en = rd_empty==0 && (occ + inflight) < BUF_DEPTH && rst_n`.
  - No combinational path from `m_axis_tready` to `rd_en`.
  - A read is accepted when `rd_en` is high.
- When the last stage of the shift register is set, `rd_data` is written at `wr_ptr` in that cycle, `occ` increments, and `wr_ptr` advances.
- `m_axis_tvalid = (occ != 0)`. `m_axis_tdata = buf[rd_ptr]`.
- On handshake (`tvalid && tready`), `rd_ptr` advances and `occ` decrements.
- Simultaneous write and pop leave `occ` unchanged.
- The credit rule guarantees a write never arrives when the buffer is full. An assertion must flag a write when `occ == BUF_DEPTH`.
- AXIS rule: once `m_axis_tvalid` is high, tdata and tlast hold until handshake. Satisfied because the head entry is only replaced on pop.
- Reset mid-operation: buffer, pointers, `occ`, in-flight bits and beat counter are all cleared asynchronously. Words already read from the FIFO are discarded. The FIFO must be reset together with this block.
- Reset values: `rd_en` 0, `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tlast` 0.

## Timing
- Read accepted in cycle T → `rd_data` sampled in cycle T+RD_LATENCY → `m_axis_tvalid` high in cycle T+RD_LATENCY+1.
- First-word latency from `rd_empty` falling, with the buffer empty: RD_LATENCY+1 cycles.
- Steady state: with `tready` held high and the FIFO non-empty, one beat per cycle, and `rd_en` stays high.
- After `tready` drops: `rd_en` deasserts once `occ + inflight` reaches BUF_DEPTH. All in-flight words still land.
- After `tready` rises: the first pop happens the same cycle. `rd_en` re-asserts the next cycle.

## Configuration
- `EASY_FIFO_TLAST_GEN_EN` defined:
  - A beat counter 0..PKT_LEN-1 advances on each handshake and wraps to 0.
  - `m_axis_tlast = m_axis_tvalid && (cnt == PKT_LEN-1)`.
  - With PKT_LEN = 1, every beat has tlast set.
- Macro undefined: `m_axis_tlast` is tied to 0, no counter is built, and PKT_LEN is ignored.

## Structure
- Shared package `easy_fifo_pkg`:
  - `BUF_DEPTH` computation as a function of RD_LATENCY.
  - Pointer width function `clog2(BUF_DEPTH)`.
  - Occupancy width function `clog2(BUF_DEPTH+1)`.
- One sub-module, `easy_fifo_rd_pipe`: the RD_LATENCY-stage valid shift register. It outputs `inflight` and a landing strobe.

## Test plan
- Reset release with FIFO holding 0xA0..0xA7, RD_LATENCY=1, tready=1 → first tvalid at cycle 2 after the first `rd_en`; 8 back-to-back beats 0xA0..0xA7 in order; `rd_en` low once `rd_empty` rises.
- RD_LATENCY=3, tready held 0, FIFO holding 10 words → exactly 5 reads issued, `occ` = 5, tdata stays 0xA0; after tready rises → 10 beats, no drops or duplicates.
- Random tready (50%) with a 1000-word stream, checked against a scoreboard → order preserved; tdata and tlast stable while tvalid is high and tready is low.
- `rd_empty` toggling every cycle with tready=1 → no read issued while empty; output matches the input sequence.
- Assert `rst_n` low while 2 words are in flight and `occ` = 3 → all outputs 0 immediately; after release, the stream resumes from a fresh FIFO with no stale beats.
- `EASY_FIFO_TLAST_GEN_EN`, PKT_LEN=4, 12 beats → tlast on beats 3, 7 and 11 only. With PKT_LEN=1 → tlast on every beat.
